// File: rtl/fg_clk_sched.sv
// fg_clk_sched: clock-enable scheduler for the function-generator datapath.
// Emits a one-cycle DDS advance strobe (fg_en) every div_active cycles while
// running, and a DAC latch strobe (dac_en) that follows it by DAC_LAG cycles.
// Divide-ratio updates are handshaked. They take effect only at a period wrap
// or on return to IDLE, so every fg_en interval uses either the old ratio or
// the new one, never a mix of the two.
module fg_clk_sched #(
    parameter int DIV_W   = 8,
    parameter int DAC_LAG = 1
) (
    input  logic             pll_clk,
    input  logic             Resetn,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             run_req,
    output logic             running,
    output logic             busy,
    output logic             fg_en,
    output logic             dac_en,
    output logic [DIV_W-1:0] div_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_active_q, div_active_d;
    logic [DIV_W-1:0]   div_pend_q, div_pend_d;
    logic               pend_q, pend_d;
    logic [DAC_LAG-1:0] dly_q, dly_d;

    logic               cfg_xfer;
    logic [DIV_W-1:0]   cfg_fixed;
    logic               wrap;

    // A requested ratio of 0 cannot produce a period, so it is stored as 1.
    assign cfg_fixed = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign wrap      = (state_q == RUN) && (cnt_q == div_active_q - DIV_W'(1));

    // The strobes are decoded from registered state only, so no input can
    // reach them combinationally.
    assign fg_en      = (state_q == RUN) && (cnt_q == '0);
    assign dac_en     = dly_q[DAC_LAG-1];
    assign cfg_ready  = !pend_q;
    assign running    = (state_q == ARM) || (state_q == RUN);
    assign busy       = (state_q != IDLE) || (dly_q != '0);
    assign div_active = div_active_q;

    // DAC delay line: next value is the current fg_en shifted in at bit 0.
    assign dly_d[0] = fg_en;
    generate
        for (genvar gi = 1; gi < DAC_LAG; gi++) begin : g_dly
            assign dly_d[gi] = dly_q[gi-1];
        end
    endgenerate

    // Next-state, counter and ratio-handshake logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        div_pend_d   = div_pend_q;
        pend_d       = pend_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_xfer) begin
                    div_active_d = cfg_fixed;
                end
                if (run_req) begin
                    state_d = ARM;
                end
            end

            ARM: begin
                cnt_d   = '0;
                state_d = RUN;
                if (cfg_xfer) begin
                    div_pend_d = cfg_fixed;
                    pend_d     = 1'b1;
                end
            end

            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_active_d = div_pend_q;
                        pend_d       = 1'b0;
                    end
                    if (!run_req) begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                // A value accepted on the wrap edge waits for the next wrap;
                // cfg_ready was high, so pend_q cannot also be set here.
                if (cfg_xfer) begin
                    div_pend_d = cfg_fixed;
                    pend_d     = 1'b1;
                end
            end

            DRAIN: begin
                cnt_d = '0;
                // Leave once the delay line will be empty after this edge,
                // so the last dac_en has already gone out.
                if (dly_d == '0) begin
                    state_d = IDLE;
                    if (pend_q) begin
                        div_active_d = div_pend_q;
                        pend_d       = 1'b0;
                    end else if (cfg_xfer) begin
                        div_active_d = cfg_fixed;
                    end
                end else if (cfg_xfer) begin
                    div_pend_d = cfg_fixed;
                    pend_d     = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge pll_clk) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_active_q <= DIV_W'(1);
            div_pend_q   <= DIV_W'(1);
            pend_q       <= 1'b0;
            dly_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            div_pend_q   <= div_pend_d;
            pend_q       <= pend_d;
            dly_q        <= dly_d;
        end
    end

endmodule
